// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the RV32M divide sequencer: operand width, opcode
// encodings, FSM state encoding and small opcode decode helpers.
package div_sequencer_pkg;

  localparam int DIV_XLEN = 32;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage <-> divider handshake: start/op/operands/flush towards the divider,
// busy/done/result back to the pipeline.
interface div_sequencer_if
  import div_sequencer_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) ();

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, data1, data2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, data1, data2, flush,
    output busy, done, result
  );

endinterface

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder, subtract the divisor when it fits.
module div_sequencer_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] dvd,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN:0]   next_rem,
  output logic [XLEN-1:0] next_dvd,
  output logic            q_bit
);

  // One spare bit above the remainder so the compare never wraps.
  logic [XLEN+1:0] rem_sh;
  logic [XLEN+1:0] dvs_ext;

  assign rem_sh   = {rem, dvd[XLEN-1]};
  assign dvs_ext  = {2'b00, dvs};
  assign q_bit    = (rem_sh >= dvs_ext);
  assign next_rem = q_bit ? (XLEN+1)'(rem_sh - dvs_ext) : rem_sh[XLEN:0];
  assign next_dvd = {dvd[XLEN-2:0], 1'b0};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for the EX stage: operand capture, sign
// handling, one restoring step per cycle, RISC-V special-case results.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; result holds the last completed value
// PREP  | take magnitudes, record signs, detect divide-by-zero / overflow
// CALC  | XLEN restoring iterations, one per cycle
// FIX   | sign-correct, pick quotient or remainder, load result
// DONE  | done pulse; a start here chains straight into PREP
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic                clk,
  input  logic                rst_n,
  div_sequencer_if.slave      bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q;
  div_op_e          op_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  dvd_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;
  logic             sign_r;
  logic             div0_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic [XLEN-1:0]  result_q;

  logic             signed_op;
  logic             div0_w;
  logic             ovf_w;
  logic [XLEN-1:0]  a_abs;
  logic [XLEN-1:0]  b_abs;
  logic [XLEN:0]    step_rem;
  logic [XLEN-1:0]  step_dvd;
  logic             step_q;
  logic [XLEN-1:0]  q_fix;
  logic [XLEN-1:0]  r_fix;
  logic [XLEN-1:0]  fix_val;

  assign signed_op = op_is_signed(op_q);
  assign div0_w    = (b_q == '0);
  assign ovf_w     = signed_op && (a_q == MIN_VAL) && (b_q == '1);
  assign a_abs     = (signed_op && a_q[XLEN-1]) ? -a_q : a_q;
  assign b_abs     = (signed_op && b_q[XLEN-1]) ? -b_q : b_q;

  div_sequencer_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .dvs      (dvs_q),
    .next_rem (step_rem),
    .next_dvd (step_dvd),
    .q_bit    (step_q)
  );

  // RISC-V defines fixed results for x/0 and MIN/-1 instead of trapping.
  always_comb begin
    q_fix   = sign_q ? -quo_q : quo_q;
    r_fix   = sign_r ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    fix_val = '0;
    if (div0_q)
      fix_val = op_is_rem(op_q) ? a_q : '1;
    else if (ovf_q)
      fix_val = op_is_rem(op_q) ? '0 : a_q;
    else
      fix_val = op_is_rem(op_q) ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= DIV_OP_DIV;
      a_q      <= '0;
      b_q      <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= div_op_e'(bus.op);
            a_q     <= bus.data1;
            b_q     <= bus.data2;
            state_q <= ST_PREP;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_PREP: begin
          dvd_q  <= a_abs;
          dvs_q  <= b_abs;
          rem_q  <= '0;
          quo_q  <= '0;
          cnt_q  <= '0;
          sign_q <= signed_op && (a_q[XLEN-1] ^ b_q[XLEN-1]);
          sign_r <= signed_op && a_q[XLEN-1];
          div0_q <= div0_w;
          ovf_q  <= ovf_w;
          state_q <= (div0_w || ovf_w) ? ST_FIX : ST_CALC;
        end
        ST_CALC: begin
          rem_q <= step_rem;
          dvd_q <= step_dvd;
          quo_q <= {quo_q[XLEN-2:0], step_q};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1))
            state_q <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= fix_val;
          state_q  <= ST_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: vector table, scoreboard queue and
// hand-written flush / reset / back-to-back sequences.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  logic [31:0] sb[$];
  vec_t vecs[15];

  always #5 clk = ~clk;

  div_sequencer_if #(.XLEN(XLEN)) bus ();

  div_sequencer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   if (b == 0) return '1; else if (ovf) return a; else return $signed(a) / $signed(b);
      2'b01:   if (b == 0) return '1; else return a / b;
      2'b10:   if (b == 0) return a;  else if (ovf) return '0; else return $signed(a) % $signed(b);
      default: if (b == 0) return a;  else return a % b;
    endcase
  endfunction

  // Called at a negedge; drives start, pushes the expected result, waits for done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name, input bit jam);
    int cyc;
    int gaps;
    logic [31:0] e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.data1 = a;
    bus.data2 = b;
    sb.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    bus.start = jam;
    cyc  = 1;
    gaps = 0;
    while (!bus.done && cyc < 60) begin
      if (!bus.busy) gaps++;
      if (jam) begin
        bus.data1 = $urandom;
        bus.data2 = $urandom;
        bus.op    = 2'($urandom_range(0, 3));
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({name, "_done"}, 32'(bus.done), 32'd1);
    check({name, "_lat"}, cyc, lat);
    check({name, "_busy_window"}, gaps, 0);
    check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    if (sb.size() == 0) begin
      check({name, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, "_result"}, bus.result, e);
    end
  endtask

  task automatic idle_check(input string name);
    @(posedge clk);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int rlat;

    vecs[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         35, "divu_100_7"};
    vecs[1]  = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35, "rem_m7_2"};
    vecs[2]  = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35, "div_m7_2"};
    vecs[3]  = '{DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  3,  "div_5_0"};
    vecs[4]  = '{DIV_OP_REMU, 32'd5,          32'd0,          32'd5,          3,  "remu_5_0"};
    vecs[5]  = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  3,  "div_ovf"};
    vecs[6]  = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          3,  "rem_ovf"};
    vecs[7]  = '{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          35, "rem_7_m2"};
    vecs[8]  = '{DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  35, "div_7_m2"};
    vecs[9]  = '{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  35, "divu_max_1"};
    vecs[10] = '{DIV_OP_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          35, "remu_max_10"};
    vecs[11] = '{DIV_OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  35, "div_min_2"};
    vecs[12] = '{DIV_OP_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  35, "rem_min_3"};
    vecs[13] = '{DIV_OP_DIVU, 32'd0,          32'd5,          32'd0,          35, "divu_0_5"};
    vecs[14] = '{DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          35, "divu_big"};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.data1 = '0;
    bus.data2 = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, 1'b0);
      idle_check(vecs[i].name);
    end

    // back-to-back: second start lands in the DONE cycle of the first
    run_op(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 35, "b2b_a", 1'b0);
    run_op(DIV_OP_DIVU, 32'd81, 32'd9, 32'd9, 35, "b2b_b", 1'b0);
    run_op(DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 3, "b2b_c", 1'b0);
    run_op(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 35, "b2b_d", 1'b0);
    idle_check("b2b");

    // flush at edge 10 of a running op
    bus.start = 1'b1;
    bus.op    = DIV_OP_DIVU;
    bus.data1 = 32'd1000;
    bus.data2 = 32'd10;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_done", 32'(bus.done), 32'd0);
    check("flush_result_hold", bus.result, 32'd14);
    dcount = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.busy) dcount++;
    end
    check("flush_no_done", dcount, 0);
    run_op(DIV_OP_DIVU, 32'd1000, 32'd10, 32'd100, 35, "after_flush", 1'b0);
    idle_check("after_flush");

    // flush and start together: start dropped
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = DIV_OP_DIV;
    bus.data1 = 32'd5;
    bus.data2 = 32'd0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_start_busy", 32'(bus.busy), 32'd0);
    dcount = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done || bus.busy) dcount++;
    end
    check("flush_start_no_op", dcount, 0);
    check("flush_start_result", bus.result, 32'd100);

    // async reset in the middle of CALC
    bus.start = 1'b1;
    bus.op    = DIV_OP_DIVU;
    bus.data1 = 32'h1234_5678;
    bus.data2 = 32'h10;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midop_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle_busy", 32'(bus.busy), 32'd0);

    // start/operand churn while busy must not disturb the running op
    run_op(DIV_OP_DIVU, 32'd1000, 32'd7, 32'd142, 35, "jam_divu", 1'b1);
    idle_check("jam_divu");
    run_op(DIV_OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 35, "jam_rem", 1'b1);
    idle_check("jam_rem");

    // random operands against the arithmetic model
    for (int k = 0; k < 12; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? MINV : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      rlat = ((rb == 0) || (!rop[0] && ra == MINV && rb == 32'hFFFF_FFFF)) ? 3 : 35;
      run_op(rop, ra, rb, model(rop, ra, rb), rlat, $sformatf("rand%0d", k), 1'b0);
    end
    idle_check("rand");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
